// File: rtl/alarm_clock_pkg.sv
// Shared constants for the alarm snooze controller.
//   - FSM state encodings (plain localparams so older code can use them).
//   - BCD digit widths.
//   - Time constants: minutes per hour and the last hour before wrap.
package alarm_clock_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StRinging = 3'd1;
  localparam state_t StStop    = 3'd2;
  localparam state_t StCalc    = 3'd3;
  localparam state_t StLoad    = 3'd4;
  localparam state_t StWait    = 3'd5;
  localparam state_t StDismiss = 3'd6;
  localparam state_t StRestore = 3'd7;

  localparam int unsigned H1_W    = 2;  // tens-of-hours digit
  localparam int unsigned DIGIT_W = 4;  // every other BCD digit

  localparam int unsigned MIN_PER_HOUR = 60;
  localparam int unsigned HOUR_WRAP    = 23;

endpackage

// File: rtl/alarm_snooze_ctrl_if.sv
// Load/stop port between the snooze controller and alarm_clock.
//   master (controller): drives H_in*/M_in*, LD_time, LD_alarm, STOP_al, AL_ON;
//                        reads Alarm and the current time H_out*/M_out*/S_out0.
//   slave  (clock):      the mirror image.
interface alarm_snooze_ctrl_if;
  import alarm_clock_pkg::*;

  logic [H1_W-1:0]    H_in1;
  logic [DIGIT_W-1:0] H_in0;
  logic [DIGIT_W-1:0] M_in1;
  logic [DIGIT_W-1:0] M_in0;
  logic               LD_time;
  logic               LD_alarm;
  logic               STOP_al;
  logic               AL_ON;

  logic               Alarm;
  logic [H1_W-1:0]    H_out1;
  logic [DIGIT_W-1:0] H_out0;
  logic [DIGIT_W-1:0] M_out1;
  logic [DIGIT_W-1:0] M_out0;
  logic [DIGIT_W-1:0] S_out0;

  modport master (
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
    input  Alarm, H_out1, H_out0, M_out1, M_out0, S_out0
  );

  modport slave (
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, STOP_al, AL_ON,
    output Alarm, H_out1, H_out0, M_out1, M_out0, S_out0
  );
endinterface

// File: rtl/bcd_time_add.sv
// Combinational BCD hh:mm + minutes adder with 23:59 -> 00:xx wrap.
//   h1/h0/m1/m0         : time in BCD
//   add_min             : minutes to add (0..59)
//   sum_h1/h0/m1/m0     : result in BCD
module bcd_time_add
  import alarm_clock_pkg::*;
(
  input  logic [H1_W-1:0]    h1,
  input  logic [DIGIT_W-1:0] h0,
  input  logic [DIGIT_W-1:0] m1,
  input  logic [DIGIT_W-1:0] m0,
  input  logic [5:0]         add_min,
  output logic [H1_W-1:0]    sum_h1,
  output logic [DIGIT_W-1:0] sum_h0,
  output logic [DIGIT_W-1:0] sum_m1,
  output logic [DIGIT_W-1:0] sum_m0
);

  logic [6:0] min_tot;
  logic [6:0] min_wrap;
  logic [4:0] hr_tot;
  logic [4:0] hr_wrap;
  logic       carry;

  always_comb begin
    // Worst case 59 + 59 = 118 fits in 7 bits.
    min_tot  = 7'(m1) * 7'd10 + 7'(m0) + 7'(add_min);
    carry    = (min_tot >= 7'(MIN_PER_HOUR));
    min_wrap = carry ? (min_tot - 7'(MIN_PER_HOUR)) : min_tot;
    hr_tot   = 5'(h1) * 5'd10 + 5'(h0);
    if (carry) begin
      hr_wrap = (hr_tot >= 5'(HOUR_WRAP)) ? 5'd0 : (hr_tot + 5'd1);
    end else begin
      hr_wrap = hr_tot;
    end
    sum_m1 = 4'(min_wrap / 7'd10);
    sum_m0 = 4'(min_wrap % 7'd10);
    sum_h1 = 2'(hr_wrap / 5'd10);
    sum_h0 = 4'(hr_wrap % 5'd10);
  end

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Snooze controller in front of the alarm_clock load/stop port.
// Arbitrates user loads against snooze reloads, runs the snooze sequence
// (stop ring, compute now+SNOOZE_MIN, reload alarm, count snoozes) and restores
// the user's saved alarm on dismiss.
//   clk, reset        : 10 Hz clock, asynchronous active-high reset
//   usr_*             : user time/alarm value, load requests, enable, dismiss
//   snooze            : snooze button level (edge detected here)
//   bus (master)      : alarm_clock load/stop port and current time / ring flag
//   snooze_cnt        : snoozes taken for the current alarm
//   snoozing          : waiting for a snooze re-ring
//   busy              : controller owns the load port, user loads ignored
// Optional feature macro: ALARM_AUTO_SNOOZE_EN (auto-snooze after RING_TIMEOUT
// seconds of unattended ringing).
module alarm_snooze_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned MAX_SNOOZE   = 3,
  parameter int unsigned LD_HOLD      = 10,
  parameter int unsigned RING_TIMEOUT = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [H1_W-1:0]    usr_H_in1,
  input  logic [DIGIT_W-1:0] usr_H_in0,
  input  logic [DIGIT_W-1:0] usr_M_in1,
  input  logic [DIGIT_W-1:0] usr_M_in0,
  input  logic               usr_LD_time,
  input  logic               usr_LD_alarm,
  input  logic               usr_AL_ON,
  input  logic               usr_STOP_al,
  input  logic               snooze,
  alarm_snooze_ctrl_if.master bus,
  output logic [3:0]         snooze_cnt,
  output logic               snoozing,
  output logic               busy
);

  localparam int unsigned HoldW = $clog2(LD_HOLD + 1);

  state_t             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               snooze_prev_q;
  logic [13:0]        saved_q, saved_d;  // {H1, H0, M1, M0}
  logic [13:0]        tin_q, tin_d;      // registered H_in/M_in
  logic               ld_time_q, ld_time_d;
  logic               ld_alarm_q, ld_alarm_d;
  logic               stop_al_q, stop_al_d;
  logic               al_on_q;
  logic               snoozing_q, snoozing_d;
  logic               busy_q, busy_d;

  logic [13:0]        sum;
  logic               snooze_req, dismiss_req, hold_done, user_path, ring_expired;

  bcd_time_add u_add (
    .h1      (bus.H_out1),
    .h0      (bus.H_out0),
    .m1      (bus.M_out1),
    .m0      (bus.M_out0),
    .add_min (6'(SNOOZE_MIN)),
    .sum_h1  (sum[13:12]),
    .sum_h0  (sum[11:8]),
    .sum_m1  (sum[7:4]),
    .sum_m0  (sum[3:0])
  );

`ifdef ALARM_AUTO_SNOOZE_EN
  localparam int unsigned RingW = $clog2(RING_TIMEOUT + 1);
  logic [RingW-1:0]   ring_cnt_q;
  logic [DIGIT_W-1:0] s_prev_q;

  // Counts seconds-digit changes while ringing; saturates at the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring_cnt_q <= '0;
      s_prev_q   <= '0;
    end else begin
      s_prev_q <= bus.S_out0;
      if (state_q != StRinging) begin
        ring_cnt_q <= '0;
      end else if ((bus.S_out0 != s_prev_q) && (ring_cnt_q != RingW'(RING_TIMEOUT))) begin
        ring_cnt_q <= ring_cnt_q + 1'b1;
      end
    end
  end
  assign ring_expired = (state_q == StRinging) && (ring_cnt_q == RingW'(RING_TIMEOUT));
`else
  logic [DIGIT_W-1:0] unused_s_out0;
  assign unused_s_out0 = bus.S_out0;
  assign ring_expired  = 1'b0;
`endif

  always_comb begin
    snooze_req  = (snooze & ~snooze_prev_q) | ring_expired;
    dismiss_req = usr_STOP_al | ~usr_AL_ON;
    hold_done   = (hold_q == HoldW'(LD_HOLD - 1));
    user_path   = (state_q == StIdle) || (state_q == StWait);

    state_d = state_q;
    cnt_d   = cnt_q;
    saved_d = saved_q;
    tin_d   = tin_q;

    case (state_q)
      StIdle:    if (bus.Alarm) state_d = StRinging;
      StRinging: begin
        // Dismiss wins over a simultaneous snooze.
        if (dismiss_req) begin
          state_d = StDismiss;
        end else if (snooze_req) begin
          state_d = (cnt_q < 4'(MAX_SNOOZE)) ? StStop : StDismiss;
        end
      end
      StStop:    if (hold_done) state_d = StCalc;
      StCalc: begin
        state_d = StLoad;
        tin_d   = sum;
      end
      StLoad: begin
        if (hold_done) begin
          state_d = StWait;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      StWait: begin
        if (dismiss_req) begin
          state_d = StDismiss;
        end else if (usr_LD_alarm) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (bus.Alarm) begin
          state_d = StRinging;
        end
      end
      StDismiss: begin
        cnt_d = '0;
        if (hold_done) state_d = StRestore;
      end
      StRestore: if (hold_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (user_path) begin
      tin_d      = {usr_H_in1, usr_H_in0, usr_M_in1, usr_M_in0};
      ld_time_d  = usr_LD_time;
      ld_alarm_d = usr_LD_alarm;
      if (usr_LD_alarm) saved_d = {usr_H_in1, usr_H_in0, usr_M_in1, usr_M_in0};
    end else begin
      ld_time_d  = 1'b0;
      ld_alarm_d = (state_d == StLoad) || (state_d == StRestore);
    end
    if (state_d == StRestore) tin_d = saved_q;

    // Pulses are timed by state residency: outputs register the next state.
    hold_d     = ((state_d != state_q) || (hold_q == HoldW'(LD_HOLD))) ? '0 : hold_q + 1'b1;
    stop_al_d  = (state_d == StStop) || (state_d == StDismiss);
    snoozing_d = (state_d == StWait);
    busy_d     = (state_d == StStop) || (state_d == StCalc) || (state_d == StLoad) ||
                 (state_d == StDismiss) || (state_d == StRestore);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      cnt_q         <= '0;
      snooze_prev_q <= 1'b0;
      saved_q       <= '0;
      tin_q         <= '0;
      ld_time_q     <= 1'b0;
      ld_alarm_q    <= 1'b0;
      stop_al_q     <= 1'b0;
      al_on_q       <= 1'b0;
      snoozing_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      snooze_prev_q <= snooze;
      saved_q       <= saved_d;
      tin_q         <= tin_d;
      ld_time_q     <= ld_time_d;
      ld_alarm_q    <= ld_alarm_d;
      stop_al_q     <= stop_al_d;
      al_on_q       <= usr_AL_ON;
      snoozing_q    <= snoozing_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.H_in1    = tin_q[13:12];
  assign bus.H_in0    = tin_q[11:8];
  assign bus.M_in1    = tin_q[7:4];
  assign bus.M_in0    = tin_q[3:0];
  assign bus.LD_time  = ld_time_q;
  assign bus.LD_alarm = ld_alarm_q;
  assign bus.STOP_al  = stop_al_q;
  assign bus.AL_ON    = al_on_q;
  assign snooze_cnt   = cnt_q;
  assign snoozing     = snoozing_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Bench for alarm_snooze_ctrl. The bench plays the alarm_clock side of the bus.
// Expected STOP_al / LD_alarm / LD_time pulses (kind, width, BCD data) are queued
// by the stimulus; a monitor measures each pulse and checks it against the queue.
module tb_alarm_snooze_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] usr_H_in1;
  logic [3:0] usr_H_in0, usr_M_in1, usr_M_in0;
  logic       usr_LD_time, usr_LD_alarm, usr_AL_ON, usr_STOP_al, snooze;
  logic [3:0] snooze_cnt;
  logic       snoozing, busy;

  alarm_snooze_ctrl_if bus ();

  alarm_snooze_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .usr_H_in1    (usr_H_in1),
    .usr_H_in0    (usr_H_in0),
    .usr_M_in1    (usr_M_in1),
    .usr_M_in0    (usr_M_in0),
    .usr_LD_time  (usr_LD_time),
    .usr_LD_alarm (usr_LD_alarm),
    .usr_AL_ON    (usr_AL_ON),
    .usr_STOP_al  (usr_STOP_al),
    .snooze       (snooze),
    .bus          (bus),
    .snooze_cnt   (snooze_cnt),
    .snoozing     (snoozing),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  localparam int KStop = 0, KLdAlarm = 1, KLdTime = 2;

  typedef struct {
    int          kind;
    int          width;
    logic [13:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic string kname(input int k);
    return (k == KStop) ? "stop_al" : (k == KLdAlarm) ? "ld_alarm" : "ld_time";
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int w, input logic [13:0] d);
    exp_t e;
    e.kind  = k;
    e.width = w;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic end_pulse(input int k, input int w, input logic [13:0] d);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL pulse_%s: got unexpected pulse of width %0d expected none", kname(k), w);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.width != w) begin
        n_errors++;
        $display("FAIL pulse_%s: got %s width %0d expected %s width %0d",
                 kname(k), kname(k), w, kname(e.kind), e.width);
      end
      if (k != KStop) begin
        n_checks++;
        if (d != e.data) begin
          n_errors++;
          $display("FAIL data_%s: got %h expected %h", kname(k), d, e.data);
        end
      end
    end
  endtask

  // Pulse monitor: index 0 STOP_al, 1 LD_alarm, 2 LD_time.
  logic [2:0]  prev_p = '0;
  int          width [3];
  logic [13:0] dat [3];

  always @(negedge clk) begin : mon
    logic [2:0] cur;
    cur = {bus.LD_time, bus.LD_alarm, bus.STOP_al};
    for (int k = 0; k < 3; k++) begin
      if (cur[k]) begin
        if (!prev_p[k]) begin
          width[k] = 0;
          dat[k]   = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
        end
        width[k]++;
      end else if (prev_p[k]) begin
        end_pulse(k, width[k], dat[k]);
      end
    end
    prev_p = cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_now(input logic [13:0] t);
    {bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0} = t;
  endtask

  // Ring (Alarm high one cycle to enter RINGING) then press snooze once.
  task automatic ring_and_snooze();
    bus.Alarm = 1'b1;
    tick();
    tick();
    snooze = 1'b1;
    tick();
    snooze    = 1'b0;
    bus.Alarm = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    {usr_H_in1, usr_H_in0, usr_M_in1, usr_M_in0} = '0;
    usr_LD_time = 0; usr_LD_alarm = 0; usr_AL_ON = 1; usr_STOP_al = 0; snooze = 0;
    bus.Alarm = 0; bus.S_out0 = '0;
    set_now(14'h0000);
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.LD_time, bus.LD_alarm, bus.STOP_al, bus.AL_ON,
                                 snoozing, busy}), 0);
    check("reset_snooze_cnt", int'(snooze_cnt), 0);
    check("reset_h_in", int'({bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0}), 0);
    tick();
    reset = 1'b0;
    tick();
    check("al_on_follows", int'(bus.AL_ON), 1);

    // 1: user alarm 10:20, ring at 10:20, snooze -> reload 10:25.
    {usr_H_in1, usr_H_in0, usr_M_in1, usr_M_in0} = 14'h1020;
    usr_LD_alarm = 1'b1;
    push(KLdAlarm, 1, 14'h1020);
    tick();
    usr_LD_alarm = 1'b0;
    set_now(14'h1020);
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h1025);
    ring_and_snooze();
    @(negedge clk);
    check("t1_busy_in_stop", int'(busy), 1);
    repeat (30) tick();
    check("t1_snooze_cnt", int'(snooze_cnt), 1);
    check("t1_snoozing", int'(snoozing), 1);

    // 2: ring at 23:58 -> reload 00:03.
    set_now(14'h2358);
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h0003);
    ring_and_snooze();
    repeat (30) tick();
    check("t2_snooze_cnt", int'(snooze_cnt), 2);

    // Third snooze: 12:57 -> 13:02.
    set_now(14'h1257);
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h1302);
    ring_and_snooze();
    repeat (30) tick();
    check("t3_snooze_cnt_max", int'(snooze_cnt), 3);

    // 3: fourth snooze acts as dismiss and restores 10:20.
    set_now(14'h1305);
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h1020);
    ring_and_snooze();
    repeat (30) tick();
    check("t3_dismiss_cnt", int'(snooze_cnt), 0);
    check("t3_dismiss_idle", int'({snoozing, busy}), 0);

    // 4: snooze and dismiss together -> dismiss path (not 08:05).
    set_now(14'h0800);
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h1020);
    bus.Alarm = 1'b1;
    tick();
    tick();
    snooze = 1'b1;
    usr_STOP_al = 1'b1;
    tick();
    snooze = 1'b0; usr_STOP_al = 1'b0; bus.Alarm = 1'b0;
    repeat (30) tick();
    check("t4_snooze_cnt", int'(snooze_cnt), 0);
    check("t4_snoozing", int'(snoozing), 0);

    // 5: unattended ringing for 61 s.
    set_now(14'h0700);
    bus.S_out0 = '0;
`ifdef ALARM_AUTO_SNOOZE_EN
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h0705);
`endif
    bus.Alarm = 1'b1;
    tick();
    for (int s = 1; s <= 60; s++) begin
      repeat (10) tick();
      bus.S_out0 = 4'(s % 10);
    end
    bus.Alarm = 1'b0;
    repeat (10) tick();
    bus.S_out0 = 4'd1;
    repeat (30) tick();
`ifdef ALARM_AUTO_SNOOZE_EN
    check("t5_auto_cnt", int'(snooze_cnt), 1);
    check("t5_auto_snoozing", int'(snoozing), 1);
`else
    check("t5_ring_cnt", int'(snooze_cnt), 0);
    check("t5_ring_flags", int'({snoozing, busy, bus.STOP_al}), 0);
    // Still ringing: a user time load must not pass through.
    usr_LD_time = 1'b1;
    tick();
    usr_LD_time = 1'b0;
    repeat (3) tick();
`endif
    push(KStop, 10, '0);
    push(KLdAlarm, 10, 14'h1020);
    usr_STOP_al = 1'b1;
    tick();
    usr_STOP_al = 1'b0;
    repeat (30) tick();
    check("t5_dismissed_cnt", int'(snooze_cnt), 0);

    // 6: reset during LOAD.
    set_now(14'h1557);
    push(KStop, 10, '0);
    push(KLdAlarm, 3, 14'h1602);
    ring_and_snooze();
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.LD_alarm) begin
        found = 1;
        break;
      end
    end
    check("t6_load_reached", int'(found), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_ld_alarm", int'(bus.LD_alarm), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_cnt", int'(snooze_cnt), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    {usr_H_in1, usr_H_in0, usr_M_in1, usr_M_in0} = 14'h1234;
    usr_LD_time = 1'b1;
    push(KLdTime, 1, 14'h1234);
    @(negedge clk);
    check("t6_ld_time_not_yet", int'(bus.LD_time), 0);
    @(posedge clk);
    #1;
    check("t6_ld_time_latency", int'(bus.LD_time), 1);
    usr_LD_time = 1'b0;

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_%s: got no pulse expected width %0d", kname(e.kind), e.width);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
